ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of the 16x16 single-port RAM block. It drives the RAM's write and read ports, and turns the RAM into a first-in-first-out queue with valid/ready handshakes on both sides. Because the RAM has a single address port, the controller arbitrates between writes and reads, and captures read data into an output register.

---
 rtl/ram_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller wrapped around a single-port 16x16 RAM.
// Turns the RAM into a first-in-first-out queue with valid/ready handshakes on
// both sides, arbitrating the single RAM address port between writes and reads
// and staging the oldest word in a registered output slot.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready/in_data       producer handshake and write word
//   out_valid/out_ready/out_data    consumer handshake and registered oldest word
//   ram_wr_en, ram_rd_en, ram_address, ram_data_in  RAM control/data outputs
//   ram_data_out      RAM read data (valid the cycle after a read issue)
//   count             words held: RAM + read in flight + output register
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W+1:0] count
);

  localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {StIdle, StWait} rd_state_e;
  typedef enum logic {GrantRead = 1'b0, GrantWrite = 1'b1} grant_e;

  rd_state_e         state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_count_q, mem_count_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic full, rd_req, wr_gnt, rd_gnt;

  // Request and grant terms depend only on registered state plus in_valid for
  // the write grant, so in_ready never looks at in_valid or out_ready.
  always_comb begin
    full     = (mem_count_q == FullCount);
    rd_req   = (mem_count_q != '0) && (state_q == StIdle) && !ov_q;
    // The side that won the last conflict yields the next one.
    in_ready = rst_n && !full && !(rd_req && (last_grant_q == GrantWrite));
    wr_gnt   = in_valid && in_ready;
    rd_gnt   = rst_n && rd_req && !wr_gnt;
  end

  always_comb begin
    ram_wr_en   = wr_gnt;
    ram_rd_en   = rd_gnt;
    ram_address = wr_gnt ? wr_ptr_q : rd_ptr_q;
    ram_data_in = in_data;
    out_valid   = ov_q;
    out_data    = out_data_q;
    count       = {1'b0, mem_count_q}
                + {{(ADDR_W+1){1'b0}}, (state_q == StWait)}
                + {{(ADDR_W+1){1'b0}}, ov_q};
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ov_d         = ov_q;
    out_data_d   = out_data_q;
    mem_count_d  = mem_count_q + {{ADDR_W{1'b0}}, wr_gnt} - {{ADDR_W{1'b0}}, rd_gnt};

    if (wr_gnt) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_gnt) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    // Arbitration history only moves on a genuine conflict.
    if (in_valid && rd_req) last_grant_d = wr_gnt ? GrantWrite : GrantRead;

    if (ov_q && out_ready) ov_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_gnt) state_d = StWait;
      end
      StWait: begin
        // RAM data is valid during the cycle after the read was issued.
        out_data_d = ram_data_out;
        ov_d       = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= GrantRead;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_count_q  <= '0;
      ov_q         <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_count_q  <= mem_count_d;
      ov_q         <= ov_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: includes a behavioural 16x16 single-port RAM,
// a cycle model of the controller's handshake/arbitration and a data scoreboard.
module tb_ram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        ram_wr_en;
  logic        ram_rd_en;
  logic [3:0]  ram_address;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;
  logic [5:0]  count;

  ram_fifo_ctrl #(
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_en   (ram_rd_en),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .count       (count)
  );

  // Single-port RAM: write committed at the edge, read data registered.
  logic [15:0] mem [16];
  always_ff @(posedge clk) begin
    if (ram_wr_en) mem[ram_address] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_address];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int npop;
  bit mon_en;
  logic [15:0] sb[$];

  // Controller reference model state.
  int       m_mc;
  bit       m_wait, m_ov, m_lastw;
  logic [3:0] m_wp, m_rp;
  bit       m_rdreq, m_inrdy, m_wg, m_rg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_mc = 0; m_wait = 0; m_ov = 0; m_lastw = 0; m_wp = 4'd0; m_rp = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  // Per-cycle monitor: checks handshake/RAM pins against the model, keeps the
  // scoreboard, then advances the model across the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        m_rdreq = (m_mc != 0) && !m_wait && !m_ov;
        m_inrdy = (m_mc != 16) && !(m_rdreq && m_lastw);
        m_wg    = in_valid && m_inrdy;
        m_rg    = m_rdreq && !m_wg;
        chk("in_ready", in_ready, m_inrdy);
        chk("ram_wr_en", ram_wr_en, m_wg);
        chk("ram_rd_en", ram_rd_en, m_rg);
        chk("wr_rd_excl", ram_wr_en & ram_rd_en, 0);
        chk("ram_address", ram_address, m_wg ? m_wp : m_rp);
        chk("ram_data_in", ram_data_in, in_data);
        chk("out_valid", out_valid, m_ov);
        chk("count", count, m_mc + m_wait + m_ov);
        if (m_wg) sb.push_back(in_data);
        if (m_ov && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL pop_underflow observed=%0h expected=none", out_data);
          end else begin
            chk("pop_data", out_data, sb.pop_front());
          end
          npop++;
        end
        if (in_valid && m_rdreq) m_lastw = m_wg;
        m_mc = m_mc + m_wg - m_rg;
        if (m_wg) m_wp = m_wp + 4'd1;
        if (m_rg) m_rp = m_rp + 4'd1;
        if (m_ov && out_ready) m_ov = 0;
        if (m_wait) m_ov = 1;
        m_wait = m_rg;
      end
    end
  end

  int          w;
  int          n0;
  logic [6:0]  exp_wr;
  logic [15:0] d;

  initial begin
    total = 0; bad = 0; npop = 0; mon_en = 0;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h0007; out_ready = 1'b0;
    model_reset();

    // Reset held two cycles with in_valid asserted.
    tick();
    tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, 0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0; mon_en = 1;

    // Single word.
    tick(); in_valid = 1'b1; in_data = 16'h0005;
    smp();
    chk("sw_wr_en", ram_wr_en, 1);
    chk("sw_wr_addr", ram_address, 0);
    chk("sw_data_in", ram_data_in, 16'h0005);
    tick(); in_valid = 1'b0;
    smp();
    chk("sw_rd_en", ram_rd_en, 1);
    chk("sw_rd_addr", ram_address, 0);
    tick(); smp();
    chk("sw_wait_out_valid", out_valid, 0);
    tick(); smp();
    chk("sw_out_valid", out_valid, 1);
    chk("sw_out_data", out_data, 16'h0005);
    chk("sw_count", count, 1);
    tick(); out_ready = 1'b1; smp();
    tick(); out_ready = 1'b0; smp();
    chk("sw_count_after_pop", count, 0);
    chk("sw_out_valid_after_pop", out_valid, 0);

    // Fill: offer 1..20, advancing only on acceptance.
    w = 1;
    for (int c = 0; c < 40; c++) begin
      tick(); in_valid = (w <= 20); in_data = 16'(w);
      smp();
      if (in_valid && in_ready) w++;
    end
    tick(); in_valid = 1'b0; smp();
    chk("fill_accepted", w - 1, 17);
    chk("fill_count", count, 17);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_out_data", out_data, 1);

    // Drain.
    for (int c = 0; c < 120 && sb.size() != 0; c++) begin
      tick(); out_ready = 1'b1; smp();
    end
    tick(); out_ready = 1'b0; smp();
    chk("drain_left", sb.size(), 0);
    chk("drain_count", count, 0);

    // Wrap: 40 words streamed through with the consumer always ready.
    n0 = npop;
    w = 1;
    for (int c = 0; c < 400; c++) begin
      tick(); out_ready = 1'b1; in_valid = (w <= 40); in_data = 16'(w);
      smp();
      if (in_valid && in_ready) w++;
      if (w > 40 && sb.size() == 0) break;
    end
    tick(); in_valid = 1'b0; out_ready = 1'b0; smp();
    chk("wrap_pops", npop - n0, 40);
    chk("wrap_left", sb.size(), 0);
    chk("wrap_count", count, 0);

    // Reset while the read FSM is in WAIT.
    tick(); in_valid = 1'b1; in_data = 16'h1111; smp();
    tick(); in_valid = 1'b0; smp();
    tick(); rst_n = 1'b0; mon_en = 0; in_valid = 1'b1; smp();
    chk("rst2_in_ready", in_ready, 0);
    chk("rst2_wr_en", ram_wr_en, 0);
    chk("rst2_rd_en", ram_rd_en, 0);
    tick(); rst_n = 1'b1; in_valid = 1'b0; model_reset(); sb.delete(); mon_en = 1;
    smp();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_count", count, 0);
    tick(); in_valid = 1'b1; in_data = 16'hABCD; smp();
    chk("abcd_wr_en", ram_wr_en, 1);
    chk("abcd_addr", ram_address, 0);
    tick(); in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (out_valid) break;
      tick();
    end
    chk("abcd_valid", out_valid, 1);
    chk("abcd_data", out_data, 16'hABCD);
    tick(); out_ready = 1'b1; smp();
    tick(); out_ready = 1'b0; smp();
    chk("abcd_count", count, 0);

    // Arbitration: in_valid held high, consumer ready.
    exp_wr = 7'b0111011;
    d = 16'h0100;
    for (int i = 0; i < 7; i++) begin
      tick(); in_valid = 1'b1; out_ready = 1'b1; in_data = d;
      smp();
      chk($sformatf("arb_wr_%0d", i), ram_wr_en, exp_wr[i]);
      chk($sformatf("arb_rd_%0d", i), ram_rd_en, !exp_wr[i]);
      if (in_ready) d = d + 16'd1;
    end
    tick(); in_valid = 1'b0;
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      smp(); tick();
    end
    out_ready = 1'b0; smp();
    chk("arb_left", sb.size(), 0);
    chk("arb_count", count, 0);

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
